// File: rtl/cnn_pkg.sv
// Shared CNN loader definitions: segment tag codes and the framer state encoding.
package cnn_pkg;

    localparam logic [1:0] TAG_MID    = 2'b00;
    localparam logic [1:0] TAG_END    = 2'b01;
    localparam logic [1:0] TAG_START  = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } framer_state_t;

endpackage

// File: rtl/frame_tag_gen.sv
// Segment tag for word `index` of a segment of `length` words (length is never 0 when used).
module frame_tag_gen
    import cnn_pkg::*;
#(
    parameter int IDX_WIDTH = 8
) (
    input  logic [IDX_WIDTH-1:0] index,
    input  logic [IDX_WIDTH-1:0] length,
    output logic [1:0]           tag
);

    always_comb begin
        tag = TAG_MID;
        if (length == IDX_WIDTH'(1)) begin
            tag = TAG_SINGLE;
        end else if (index == '0) begin
            tag = TAG_START;
        end else if (index == length - IDX_WIDTH'(1)) begin
            tag = TAG_END;
        end
    end

endmodule

// File: rtl/ifmap_stream_framer.sv
// Frames raw ifmap samples into tagged words for the IFmap buffer, with an optional zero flush row.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start with a non-zero row_len
// ST_DATA  | loading one framed word per accepted source sample
// ST_FLUSH | loading zero words until flush_len have been loaded
// ST_DRAIN | last word held in the output register, waiting for it to move
module ifmap_stream_framer
    import cnn_pkg::*;
#(
    parameter int IFMAP_BUFFER_WIDTH = 18,
    parameter int DATA_WIDTH         = 16,
    parameter int LEN_WIDTH          = 8,
    parameter int FILTER_SIZE_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LEN_WIDTH-1:0]          row_len,
    input  logic [FILTER_SIZE_WIDTH-1:0]  flush_len,
    input  logic [DATA_WIDTH-1:0]         src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in,
    output logic                          IFmap_buffer_write_enable,
    input  logic                          IFmap_buffer_ready,
    output logic                          busy,
    output logic                          done
);

    framer_state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]          idx_q, idx_d;
    logic [LEN_WIDTH-1:0]          row_len_q, row_len_d;
    logic [FILTER_SIZE_WIDTH-1:0]  flush_len_q, flush_len_d;
    logic [IFMAP_BUFFER_WIDTH-1:0] word_q, word_d;
    logic                          wen_q, wen_d;
    logic                          done_q, done_d;

    logic [LEN_WIDTH-1:0]          seg_len;
    logic [LEN_WIDTH-1:0]          last_idx;
    logic [1:0]                    tag;
    logic                          xfer;
    logic                          slot_free;

    assign xfer      = wen_q && IFmap_buffer_ready;
    // The single output register can take a new word when empty or when its word moves this edge.
    assign slot_free = !wen_q || IFmap_buffer_ready;
    assign seg_len   = (state_q == ST_FLUSH) ? LEN_WIDTH'(flush_len_q) : row_len_q;
    assign last_idx  = seg_len - LEN_WIDTH'(1);

    frame_tag_gen #(
        .IDX_WIDTH (LEN_WIDTH)
    ) u_tag_gen (
        .index  (idx_q),
        .length (seg_len),
        .tag    (tag)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_len_d   = row_len_q;
        flush_len_d = flush_len_q;
        word_d      = word_q;
        wen_d       = wen_q;
        done_d      = 1'b0;
        src_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && row_len != '0) begin
                    row_len_d   = row_len;
                    flush_len_d = flush_len;
                    idx_d       = '0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                src_ready = slot_free;
                if (xfer) begin
                    wen_d = 1'b0;
                end
                if (src_valid && slot_free) begin
                    word_d = {tag, src_data};
                    wen_d  = 1'b1;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = (flush_len_q != '0) ? ST_FLUSH : ST_DRAIN;
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    word_d = {tag, DATA_WIDTH'(0)};
                    wen_d  = 1'b1;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    wen_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            row_len_q   <= '0;
            flush_len_q <= '0;
            word_q      <= '0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_len_q   <= row_len_d;
            flush_len_q <= flush_len_d;
            word_q      <= word_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
        end
    end

    assign IFmap_buffer_in           = word_q;
    assign IFmap_buffer_write_enable = wen_q;
    assign done                      = done_q;
    assign busy                      = (state_q != ST_IDLE);

endmodule
